pipeline_ctrl: RTL and testbench

Parametrised hazard and stall controller for the in-order RISC-V pipeline. It replaces the per-pipe `busywait` tie-offs with real per-stage hold and flush control. It also tracks a live-valid bit and destination-register shadow for every stage, and adds instruction-memory and data-memory wait handling, a halt/drain mode and performance counters. It sits beside the stage pipes in the CPU top and drives each pipe register's hold and flush inputs.

---
 rtl/cpu_ctrl_pkg.sv | 32 +++
 rtl/pipeline_ctrl_stage.sv | 31 +++
 rtl/pipeline_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and stage-index helpers for the in-order pipeline hazard/stall controller.
package cpu_ctrl_pkg;

  // Widest register address the shadow pipeline can carry; narrower RA_W is zero-extended.
  localparam int RD_MAX_W = 8;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                reg_write;
    logic                is_load;
  } shadow_t;

  function automatic int ex_idx();
    return 2;
  endfunction

  function automatic int mem_idx(input int n);
    return n - 2;
  endfunction

  function automatic int wb_idx(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_stage.sv
// One shadow stage register: holds, loads a bubble, or copies the previous stage.
module pipeline_ctrl_stage
  import cpu_ctrl_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    hold_i,
  input  logic    kill_i,
  input  shadow_t prev_i,
  output shadow_t cur_o
);

  shadow_t cur_q, cur_d;

  // NOTE: next-state logic assigns a default first so no path leaves cur_d unassigned (no latch).
  always_comb begin
    cur_d = cur_q;
    if (!hold_i) begin
      cur_d = kill_i ? '0 : prev_i;
    end
  end

  // NOTE: state registers use non-blocking assignment and clear asynchronously on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur_q <= '0;
    else       cur_q <= cur_d;
  end

  assign cur_o = cur_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller: per-stage hold and flush, shadow valid/rd tracking,
// memory wait handling, halt/drain FSM and performance counters.
module pipeline_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int NSTAGES = 5,
  parameter int RA_W    = 5,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [RA_W-1:0]    id_rs1,
  input  logic [RA_W-1:0]    id_rs2,
  input  logic               id_rs1_used,
  input  logic               id_rs2_used,
  input  logic [RA_W-1:0]    id_rd,
  input  logic               id_reg_write,
  input  logic               id_is_load,
  input  logic               ex_redirect,
  input  logic               imem_busy,
  input  logic               dmem_busy,
  input  logic               halt_req,
  output logic [NSTAGES-1:0] stall,
  output logic [NSTAGES-1:0] flush,
  output logic [NSTAGES-1:0] valid,
  output logic               retire,
  output logic               halted,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   retire_cnt,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam int EX  = ex_idx();
  localparam int MEM = mem_idx(NSTAGES);
  localparam int WB  = wb_idx(NSTAGES);

  ctrl_state_t state_q, state_d;
  logic [CNT_W-1:0] cycle_q, cycle_d, retire_q, retire_d, stallc_q, stallc_d;

  shadow_t [NSTAGES-1:1] sh_q;
  shadow_t [NSTAGES-1:1] sh_in;
  logic    [NSTAGES-1:0] valid_w, stall_w, flush_w;
  logic    [NSTAGES-1:1] kill_w;
  logic [RD_MAX_W-1:0]   rs1_ext, rs2_ext;
  logic d_wait, redirect, load_use;
  logic unused_shadow_bits;

  assign rs1_ext = RD_MAX_W'(id_rs1);
  assign rs2_ext = RD_MAX_W'(id_rs2);

  always_comb begin
    valid_w    = '0;
    valid_w[0] = ~imem_busy & (state_q == ST_RUN);
    for (int k = 1; k < NSTAGES; k++) valid_w[k] = sh_q[k].valid;
  end

  // A live ID instruction reading a non-x0 register written by a live load in EX..MEM-1.
  always_comb begin
    load_use = 1'b0;
    for (int k = EX; k < MEM; k++) begin
      if (sh_q[k].valid && sh_q[k].reg_write && sh_q[k].is_load) begin
        if (id_rs1_used && rs1_ext != '0 && rs1_ext == sh_q[k].rd) load_use = 1'b1;
        if (id_rs2_used && rs2_ext != '0 && rs2_ext == sh_q[k].rd) load_use = 1'b1;
      end
    end
    load_use = load_use & sh_q[1].valid;
  end

  assign d_wait   = valid_w[MEM] & dmem_busy;
  assign redirect = ex_redirect & valid_w[EX];

  always_comb begin
    stall_w = '0;
    flush_w = '0;
    kill_w  = '0;
    if (d_wait) begin
      stall_w[MEM:0] = '1;
      kill_w[WB]     = 1'b1;
    end else if (redirect) begin
      // The squashed IF and ID instructions land in ID and EX as bubbles.
      flush_w[1:0] = 2'b11;
      kill_w[EX]   = 1'b1;
    end else if (load_use) begin
      stall_w[1:0] = 2'b11;
      kill_w[EX]   = 1'b1;
    end else if (imem_busy || state_q != ST_RUN) begin
      stall_w[0] = 1'b1;
      kill_w[1]  = 1'b1;
    end
  end

  // ID decode fields enter the shadow as the instruction moves into EX.
  always_comb begin
    sh_in                 = '0;
    sh_in[1].valid        = valid_w[0];
    sh_in[EX].valid       = sh_q[1].valid;
    sh_in[EX].rd          = RD_MAX_W'(id_rd);
    sh_in[EX].reg_write   = id_reg_write;
    sh_in[EX].is_load     = id_is_load;
    for (int k = EX + 1; k < NSTAGES; k++) sh_in[k] = sh_q[k-1];
  end

  for (genvar k = 1; k < NSTAGES; k++) begin : g_stage
    pipeline_ctrl_stage u_stage (
      .clk    (clk),
      .reset  (reset),
      .hold_i (stall_w[k]),
      .kill_i (flush_w[k] | kill_w[k]),
      .prev_i (sh_in[k]),
      .cur_o  (sh_q[k])
    );
  end

  // Leave DRAIN once ID..MEM are empty; the last WB instruction retires on that same edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (halt_req)          state_d = ST_DRAIN;
      ST_DRAIN:  if (~|valid_w[MEM:1])  state_d = ST_HALTED;
      ST_HALTED: if (!halt_req)         state_d = ST_RUN;
      default:                          state_d = ST_RUN;
    endcase
  end

  always_comb begin
    cycle_d  = cycle_q;
    retire_d = retire_q;
    stallc_d = stallc_q;
    if (state_q != ST_HALTED)             cycle_d  = cycle_q + CNT_W'(1);
    if (valid_w[WB])                      retire_d = retire_q + CNT_W'(1);
    if (state_q == ST_RUN && stall_w[0])  stallc_d = stallc_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_RUN;
      cycle_q  <= '0;
      retire_q <= '0;
      stallc_q <= '0;
    end else begin
      state_q  <= state_d;
      cycle_q  <= cycle_d;
      retire_q <= retire_d;
      stallc_q <= stallc_d;
    end
  end

  assign unused_shadow_bits = ^{sh_q[1].rd, sh_q[1].reg_write, sh_q[1].is_load,
                                sh_q[WB].rd, sh_q[WB].reg_write, sh_q[WB].is_load};

  assign stall      = stall_w;
  assign flush      = flush_w;
  assign valid      = valid_w;
  assign retire     = valid_w[WB];
  assign halted     = (state_q == ST_HALTED);
  assign cycle_cnt  = cycle_q;
  assign retire_cnt = retire_q;
  assign stall_cnt  = stallc_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: 5-stage instance for hazards/halt/reset, 7-stage for depth.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_rs1_used, id_rs2_used, id_reg_write, id_is_load;
  logic       ex_redirect, imem_busy, dmem_busy, halt_req;

  logic [4:0]  stall5, flush5, valid5;
  logic [6:0]  stall7, flush7, valid7;
  logic        retire5, halted5, retire7, halted7;
  logic [31:0] cyc5, ret5, stc5, cyc7, ret7, stc7;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.NSTAGES(5)) u5 (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .ex_redirect(ex_redirect), .imem_busy(imem_busy), .dmem_busy(dmem_busy), .halt_req(halt_req),
    .stall(stall5), .flush(flush5), .valid(valid5), .retire(retire5), .halted(halted5),
    .cycle_cnt(cyc5), .retire_cnt(ret5), .stall_cnt(stc5)
  );

  pipeline_ctrl #(.NSTAGES(7)) u7 (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .ex_redirect(ex_redirect), .imem_busy(imem_busy), .dmem_busy(dmem_busy), .halt_req(halt_req),
    .stall(stall7), .flush(flush7), .valid(valid7), .retire(retire7), .halted(halted7),
    .cycle_cnt(cyc7), .retire_cnt(ret7), .stall_cnt(stc7)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic set_id(input logic [4:0] rd, input logic rw, input logic ld,
                        input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2);
    id_rd = rd; id_reg_write = rw; id_is_load = ld;
    id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
  endtask

  initial begin
    reset = 1'b1; imem_busy = 1'b1; dmem_busy = 1'b0; ex_redirect = 1'b0; halt_req = 1'b0;
    set_id(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    #12;
    check("rst_valid",  valid5,  5'b00000);
    check("rst_stall",  stall5,  5'b00001);
    check("rst_flush",  flush5,  5'b00000);
    check("rst_retire", retire5, 1'b0);
    check("rst_halted", halted5, 1'b0);
    check("rst_cyc",    cyc5,    32'd0);
    check("rst_ret",    ret5,    32'd0);
    check("rst_stc",    stc5,    32'd0);
    check("rst_valid7", valid7,  7'b0000000);

    // N0: release reset, start fetching.
    nxt(); reset = 1'b0; imem_busy = 1'b0;
    // N1: lw x5 in ID.
    nxt(); set_id(5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1 check("lu_pre_valid", valid5, 5'b00011);
    // N2: lw x5 in EX, ID reads x5.
    nxt(); set_id(5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
    #1 check("lu_stall", stall5, 5'b00011);
    check("lu_flush", flush5, 5'b00000);
    check("lu_valid", valid5, 5'b00111);
    // N3: one bubble in EX, stall released.
    nxt();
    #1 check("lu_bubble_valid", valid5, 5'b01011);
    check("lu_release", stall5, 5'b00000);
    // N4: redirect with live EX.
    nxt(); ex_redirect = 1'b1; set_id(5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1 check("rd_valid", valid5, 5'b10111);
    check("rd_retire", retire5, 1'b1);
    check("rd_flush", flush5, 5'b00011);
    check("rd_stall", stall5, 5'b00000);
    // N5: ID and EX now bubbles.
    nxt(); ex_redirect = 1'b0; set_id(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    #1 check("rd_after_valid", valid5, 5'b01001);
    check("rd_after_retire", retire5, 1'b0);
    // N6: lw x7 in ID.
    nxt(); set_id(5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    // N7: redirect coincident with load-use on x7.
    nxt(); ex_redirect = 1'b1; set_id(5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
    #1 check("rdlu_stall", stall5, 5'b00000);
    check("rdlu_flush", flush5, 5'b00011);
    // N8
    nxt(); ex_redirect = 1'b0; set_id(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    #1 check("rdlu_after_valid", valid5, 5'b01001);
    // N9, N10: fill ID/EX/MEM.
    nxt(); set_id(5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    nxt(); set_id(5'd10, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    // N11..N13: D-wait with a pending redirect.
    nxt(); dmem_busy = 1'b1; ex_redirect = 1'b1;
    #1 check("dw_valid", valid5, 5'b01111);
    check("dw_stall1", stall5, 5'b01111);
    check("dw_flush", flush5, 5'b00000);
    check("dw_stc_before", stc5, 32'd1);
    nxt();
    #1 check("dw_stall2", stall5, 5'b01111);
    check("dw_retire2", retire5, 1'b0);
    nxt();
    #1 check("dw_stall3", stall5, 5'b01111);
    check("dw_retire3", retire5, 1'b0);
    // N14: release; pending redirect acts now.
    nxt(); dmem_busy = 1'b0;
    #1 check("dw_rel_stall", stall5, 5'b00000);
    check("dw_rel_flush", flush5, 5'b00011);
    check("dw_retire4", retire5, 1'b0);
    check("dw_stc_after", stc5, 32'd4);
    // N15: then an async reset pulse inside a D-wait.
    nxt(); ex_redirect = 1'b0;
    #1 check("dw_post_valid", valid5, 5'b11001);
    check("dw_post_retire", retire5, 1'b1);
    dmem_busy = 1'b1;
    #1 check("ar_pre_stall", stall5, 5'b01111);
    reset = 1'b1;
    #1 check("ar_valid", valid5, 5'b00001);
    check("ar_stall", stall5, 5'b00000);
    check("ar_cyc", cyc5, 32'd0);
    check("ar_ret", ret5, 32'd0);
    check("ar_stc", stc5, 32'd0);
    check("ar_halted", halted5, 1'b0);
    reset = 1'b0; dmem_busy = 1'b0;
    set_id(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    // N16..N18: refill, then request halt.
    nxt(); nxt(); nxt(); halt_req = 1'b1;
    #1 check("ht_valid", valid5, 5'b01111);
    // N19: DRAIN.
    nxt();
    #1 check("ht_drain_stall", stall5, 5'b00001);
    check("ht_drain_valid", valid5, 5'b11110);
    check("ht_drain_halted", halted5, 1'b0);
    nxt(); nxt(); nxt();
    #1 check("ht_n22_valid", valid5, 5'b10000);
    check("ht_n22_halted", halted5, 1'b0);
    // N23: HALTED.
    nxt();
    #1 check("ht_halted", halted5, 1'b1);
    check("ht_ret", ret5, 32'd4);
    check("ht_cyc", cyc5, 32'd8);
    nxt(); nxt(); halt_req = 1'b0;
    #1 check("ht_frozen_cyc", cyc5, 32'd8);
    check("ht_still_halted", halted5, 1'b1);
    // N26: back to RUN; then an I-wait.
    nxt();
    #1 check("rs_halted", halted5, 1'b0);
    check("rs_valid", valid5, 5'b00001);
    check("rs_stc", stc5, 32'd0);
    imem_busy = 1'b1;
    #1 check("iw_stall", stall5, 5'b00001);
    check("iw_valid", valid5, 5'b00000);
    nxt(); imem_busy = 1'b0;
    #1 check("iw_bubble_valid", valid5, 5'b00001);
    check("iw_stc", stc5, 32'd1);

    // Depth: 7-stage instance, load in stage 3 then x0.
    nxt(); reset = 1'b1;
    #2 reset = 1'b0;
    nxt(); set_id(5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1 check("d7_valid1", valid7, 7'b0000011);
    nxt(); set_id(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    nxt(); set_id(5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
    #1 check("d7_stall1", stall7, 7'b0000011);
    check("d7_valid3", valid7, 7'b0001111);
    check("d7_flush", flush7, 7'b0000000);
    nxt();
    #1 check("d7_stall2", stall7, 7'b0000011);
    check("d7_valid4", valid7, 7'b0011011);
    nxt();
    #1 check("d7_release", stall7, 7'b0000000);
    check("d7_valid5", valid7, 7'b0110011);
    nxt(); set_id(5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    nxt(); set_id(5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0);
    #1 check("d7_x0_ex", stall7, 7'b0000000);
    nxt();
    #1 check("d7_x0_st3", stall7, 7'b0000000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
